apb_pwm_master: RTL and testbench

//  APB requester (initiator) that drives the apb_pwm slave, or any APB3-style completer,

---
 rtl/apb_pwm_master.sv | 155 +++++++++++++++
 tb/tb_apb_pwm_master.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_pwm_master.sv
// APB3 requester: turns one accepted command into one SETUP/ACCESS transfer,
// with a bounded PREADY wait so a hung completer cannot stall the issuer.
module apb_pwm_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [DATA_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic                  PSERR,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_paddr, w_paddr_nxt;
    logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nxt;
    logic                  r_pwrite, w_pwrite_nxt;
    logic                  r_psel, w_psel_nxt;
    logic                  r_penable, w_penable_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic                  r_rsp_err, w_rsp_err_nxt;
    logic                  r_rsp_timeout, w_rsp_timeout_nxt;
    logic                  w_accept;

    assign cmd_ready = (r_state == ST_IDLE) && PRESETn;
    assign busy      = (r_state != ST_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_paddr_nxt       = r_paddr;
        w_pwdata_nxt      = r_pwdata;
        w_pwrite_nxt      = r_pwrite;
        w_psel_nxt        = r_psel;
        w_penable_nxt     = r_penable;
        w_rsp_valid_nxt   = 1'b0;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_err_nxt     = r_rsp_err;
        w_rsp_timeout_nxt = r_rsp_timeout;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = ST_SETUP;
                    w_paddr_nxt   = cmd_addr;
                    w_pwdata_nxt  = cmd_wdata;
                    w_pwrite_nxt  = cmd_write;
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b0;
                end
            end
            ST_SETUP: begin
                w_state_nxt   = ST_ACCESS;
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    w_state_nxt       = ST_IDLE;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_err_nxt     = PSERR;
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_rdata_nxt   = r_pwrite ? '0 : PRDATA;
                end else if (r_cnt == CNT_LAST) begin
                    // Abort: completer never answered within the wait budget.
                    w_state_nxt       = ST_IDLE;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_psel_nxt    = 1'b0;
                w_penable_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous so the bus drops at once.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pwrite      <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_paddr       <= w_paddr_nxt;
            r_pwdata      <= w_pwdata_nxt;
            r_pwrite      <= w_pwrite_nxt;
            r_psel        <= w_psel_nxt;
            r_penable     <= w_penable_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign PWRITE      = r_pwrite;
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_pwm_master.sv
// Bench for apb_pwm_master: a behavioural APB completer with programmable wait states,
// errors and hangs, plus a transaction-level model predicting each response.
module tb_apb_pwm_master;

    localparam int DW = 32;
    localparam int T  = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [DW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          busy;
    logic [DW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic          PREADY = 1'b0;
    logic          PSERR = 1'b0;
    logic [DW-1:0] PRDATA = '0;

    apb_pwm_master #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PREADY(PREADY), .PSERR(PSERR), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic          got;
        logic [7:0]    acc_wait;
        logic [7:0]    lat;
        logic [7:0]    pen;
        logic          phase_ok;
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
    } txn_res_t;

    int checks = 0;
    int errors = 0;

    // Completer behaviour knobs and storage.
    int s_waits = 0;
    bit s_err   = 1'b0;
    bit s_hang  = 1'b0;
    int s_acc   = 0;
    logic [DW-1:0] smem [logic [DW-1:0]];

    // Expected register contents as seen by the issuer.
    logic [DW-1:0] mm [logic [DW-1:0]];

    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            PREADY = !s_hang && (s_acc >= s_waits);
            PSERR  = PREADY ? s_err : 1'($urandom);
            if (PREADY && !PWRITE)
                PRDATA = smem.exists(PADDR) ? smem[PADDR] : '0;
            else
                PRDATA = $urandom;
            if (PREADY && PWRITE && !s_err)
                smem[PADDR] = PWDATA;
            s_acc++;
        end else begin
            // Garbage outside ACCESS must be ignored by the requester.
            s_acc  = 0;
            PREADY = 1'($urandom);
            PSERR  = 1'($urandom);
            PRDATA = $urandom;
        end
    end

    function automatic string fmt(input txn_res_t r);
        return $sformatf("got=%0b acc_wait=%0d lat=%0d pen=%0d phase_ok=%0b rdata=%h err=%0b tmo=%0b",
                         r.got, r.acc_wait, r.lat, r.pen, r.phase_ok, r.rdata, r.err, r.tmo);
    endfunction

    // Transaction-level prediction from the protocol rules.
    function automatic txn_res_t predict(input logic w, input logic [DW-1:0] a, input logic [DW-1:0] d,
                                         input int waits, input bit err, input bit hang);
        txn_res_t e;
        bit tmo;
        tmo        = hang || (waits >= T);
        e          = '0;
        e.got      = 1'b1;
        e.acc_wait = 8'd0;
        e.phase_ok = 1'b1;
        e.lat      = tmo ? 8'(T + 2) : 8'(waits + 3);
        e.pen      = tmo ? 8'(T) : 8'(waits + 1);
        e.tmo      = tmo;
        e.err      = tmo || err;
        e.rdata    = (tmo || w) ? '0 : (mm.exists(a) ? mm[a] : '0);
        if (w && !tmo && !err) mm[a] = d;
        return e;
    endfunction

    // Issues one command from a negedge and observes it until the response (or a bound).
    task automatic run_cmd(input logic w, input logic [DW-1:0] a, input logic [DW-1:0] d,
                           output txn_res_t r);
        int guard;
        r          = '0;
        r.phase_ok = 1'b1;
        cmd_valid  = 1'b1;
        cmd_write  = w;
        cmd_addr   = a;
        cmd_wdata  = d;
        guard      = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge PCLK);
            guard++;
        end
        r.acc_wait = 8'(guard);
        @(posedge PCLK);
        for (int k = 1; k <= 40; k++) begin
            @(negedge PCLK);
            if (k == 1) begin
                cmd_valid = 1'b0;
                cmd_write = 1'($urandom);
                cmd_addr  = $urandom;
                cmd_wdata = $urandom;
                if (!(PSEL && !PENABLE && busy && !cmd_ready && !rsp_valid)) r.phase_ok = 1'b0;
            end
            if (PSEL && PENABLE) r.pen++;
            if (PSEL && (PADDR !== a || PWRITE !== w || PWDATA !== d)) r.phase_ok = 1'b0;
            if (rsp_valid) begin
                r.got   = 1'b1;
                r.lat   = 8'(k);
                r.rdata = rsp_rdata;
                r.err   = rsp_err;
                r.tmo   = rsp_timeout;
                if (PSEL || PENABLE || busy || !cmd_ready || PADDR !== a || PWRITE !== w)
                    r.phase_ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'hFF;
        cmd_wdata = 32'hFF;
        #12;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy, PADDR, PSEL,
             PENABLE, PWRITE, PWDATA} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%0b rsp_valid=%0b busy=%0b psel=%0b penable=%0b paddr=%h pwdata=%h want all zero",
                     cmd_ready, rsp_valid, busy, PSEL, PENABLE, PADDR, PWDATA);
        end
        cmd_valid = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        checks++;
        if ({cmd_ready, busy, PSEL, rsp_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_release got ready/busy/psel/rsp=%b want 1000",
                     {cmd_ready, busy, PSEL, rsp_valid});
        end
    endtask

    task automatic test_pwm_writes();
        logic [DW-1:0] addrs [4];
        logic [DW-1:0] datas [4];
        txn_res_t e, o;
        addrs = '{32'h0, 32'h4, 32'hC, 32'h8};
        datas = '{32'd30, 32'd10, 32'd20, 32'd1};
        s_waits = 0; s_err = 1'b0; s_hang = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = predict(1'b1, addrs[i], datas[i], 0, 1'b0, 1'b0);
            run_cmd(1'b1, addrs[i], datas[i], o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pwm_write_%0d got {%s} want {%s}", i, fmt(o), fmt(e));
            end
            @(negedge PCLK);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rsp_pulse_%0d got rsp_valid=%0b want 0", i, rsp_valid);
            end
        end
    endtask

    task automatic test_read();
        txn_res_t e, o;
        e = predict(1'b0, 32'h4, 32'h0, 0, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h4, 32'h0, o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL read_4 got {%s} want {%s}", fmt(o), fmt(e));
        end
        checks++;
        if (o.rdata !== 32'd10) begin
            errors++;
            $display("FAIL read_4_value got %0d want 10", o.rdata);
        end
    endtask

    task automatic test_wait_states();
        txn_res_t e, o;
        s_waits = 5;
        e = predict(1'b1, 32'h20, 32'hA5A5_1234, 5, 1'b0, 1'b0);
        run_cmd(1'b1, 32'h20, 32'hA5A5_1234, o);
        checks++;
        if (o !== e || o.lat !== 8'd8 || o.pen !== 8'd6) begin
            errors++;
            $display("FAIL wait5_write got {%s} want {%s}", fmt(o), fmt(e));
        end
        s_waits = 3;
        e = predict(1'b0, 32'h20, 32'h0, 3, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h20, 32'h0, o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL wait3_read got {%s} want {%s}", fmt(o), fmt(e));
        end
        s_waits = 0;
    endtask

    task automatic test_slave_error();
        txn_res_t e, o;
        s_err = 1'b1;
        e = predict(1'b1, 32'h24, 32'h5555_0000, 0, 1'b1, 1'b0);
        run_cmd(1'b1, 32'h24, 32'h5555_0000, o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL pslverr_write got {%s} want {%s}", fmt(o), fmt(e));
        end
        s_waits = 2;
        e = predict(1'b0, 32'h0, 32'h0, 2, 1'b1, 1'b0);
        run_cmd(1'b0, 32'h0, 32'h0, o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL pslverr_read got {%s} want {%s}", fmt(o), fmt(e));
        end
        s_err = 1'b0; s_waits = 0;
        e = predict(1'b0, 32'hC, 32'h0, 0, 1'b0, 1'b0);
        run_cmd(1'b0, 32'hC, 32'h0, o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL after_err_read got {%s} want {%s}", fmt(o), fmt(e));
        end
    endtask

    task automatic test_timeout();
        txn_res_t e, o;
        s_hang = 1'b1;
        e = predict(1'b0, 32'h8, 32'h0, 0, 1'b0, 1'b1);
        run_cmd(1'b0, 32'h8, 32'h0, o);
        checks++;
        if (o !== e || o.pen !== 8'd16 || o.tmo !== 1'b1) begin
            errors++;
            $display("FAIL hang_read got {%s} want {%s}", fmt(o), fmt(e));
        end
        e = predict(1'b1, 32'h28, 32'hDEAD_BEEF, 0, 1'b0, 1'b1);
        run_cmd(1'b1, 32'h28, 32'hDEAD_BEEF, o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL hang_write got {%s} want {%s}", fmt(o), fmt(e));
        end
        s_hang = 1'b0;
        s_waits = T - 1;
        e = predict(1'b1, 32'h2C, 32'h1357_9BDF, T - 1, 1'b0, 1'b0);
        run_cmd(1'b1, 32'h2C, 32'h1357_9BDF, o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL max_waits got {%s} want {%s}", fmt(o), fmt(e));
        end
        s_waits = T;
        e = predict(1'b0, 32'h2C, 32'h0, T, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h2C, 32'h0, o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL late_ready got {%s} want {%s}", fmt(o), fmt(e));
        end
        s_waits = 0;
    endtask

    task automatic test_back_to_back();
        txn_res_t e, o;
        logic w;
        logic [DW-1:0] a, d;
        s_waits = 0; s_err = 1'b0; s_hang = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w = (i % 2 == 0);
            a = 32'h40 + 32'(4 * (i / 2));
            d = $urandom;
            e = predict(w, a, d, 0, 1'b0, 1'b0);
            run_cmd(w, a, d, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_%0d got {%s} want {%s}", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_random();
        txn_res_t e, o;
        logic w;
        logic [DW-1:0] a, d;
        int waits;
        bit err, hang;
        for (int i = 0; i < 40; i++) begin
            w     = 1'($urandom);
            a     = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            d     = $urandom;
            waits = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 4) : $urandom_range(0, T + 1);
            err   = ($urandom_range(0, 5) == 0);
            hang  = ($urandom_range(0, 9) == 0);
            s_waits = waits; s_err = err; s_hang = hang;
            e = predict(w, a, d, waits, err, hang);
            run_cmd(w, a, d, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rand_%0d w=%0b a=%h waits=%0d err=%0b hang=%0b got {%s} want {%s}",
                         i, w, a, waits, err, hang, fmt(o), fmt(e));
            end
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
        end
        s_waits = 0; s_err = 1'b0; s_hang = 1'b0;
    endtask

    task automatic test_reset_mid();
        txn_res_t e, o;
        bit saw_rsp;
        s_hang    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h4;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            errors++;
            $display("FAIL mid_in_access got psel/penable=%b want 11", {PSEL, PENABLE});
        end
        #2 PRESETn = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, busy, rsp_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_async_drop got psel/penable/busy/rsp=%b want 0000",
                     {PSEL, PENABLE, busy, rsp_valid});
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        s_hang  = 1'b0;
        saw_rsp = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge PCLK);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        checks++;
        if (saw_rsp !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_after_release got saw_rsp=%0b ready=%0b want 0 1", saw_rsp, cmd_ready);
        end
        e = predict(1'b0, 32'h4, 32'h0, 1, 1'b0, 1'b0);
        s_waits = 1;
        run_cmd(1'b0, 32'h4, 32'h0, o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL mid_recover got {%s} want {%s}", fmt(o), fmt(e));
        end
        s_waits = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pwm_writes();
        test_read();
        test_wait_states();
        test_slave_error();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
